// File: rtl/uart_frame_receiver.sv
// UART receive end: 12-bit frame (start, 8 data LSB first, parity, two stops)
// sampled at bit centres by a bit-period counter on the system clock.
module uart_frame_receiver #(
    parameter int   CLKS_PER_BIT = 1085,
    parameter logic PARITY_ODD   = 1'b0
) (
    input  logic       CLOCK_125_p,
    input  logic       KEY0,
    input  logic       Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       check_parity,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    function automatic logic calc_parity(input logic [7:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    state_t          state_q;
    logic            sync1_q, sync2_q, rx_prev_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_bit_q, stop1_q, stop2_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q, check_parity_q, frame_err_q, busy_q;
    logic            rx_s, fall_s, tick_s;

    assign rx_s   = sync2_q;
    assign fall_s = rx_prev_q & ~sync2_q;
    assign tick_s = (cnt_q == '0);

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign check_parity = check_parity_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

    // Two-flop synchroniser for the asynchronous Rx pin plus a delayed copy for edge detection
    always_ff @(posedge CLOCK_125_p or negedge KEY0) begin
        if (!KEY0) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= Rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // Frame FSM with bit-centre sampling and registered result outputs
    always_ff @(posedge CLOCK_125_p or negedge KEY0) begin
        if (!KEY0) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 8'h00;
            par_bit_q      <= 1'b0;
            stop1_q        <= 1'b0;
            stop2_q        <= 1'b0;
            rx_data_q      <= 8'h00;
            rx_valid_q     <= 1'b0;
            check_parity_q <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fall_s) begin
                        cnt_q     <= HALF_M1;
                        bit_cnt_q <= 4'd0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (!tick_s) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (rx_s) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= FULL_M1;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        shift_q   <= {rx_s, shift_q[7:1]};
                        cnt_q     <= FULL_M1;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_q <= S_PARITY;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_s) begin
                        par_bit_q <= rx_s;
                        cnt_q     <= FULL_M1;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        state_q   <= S_STOP1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_STOP1: begin
                    if (tick_s) begin
                        stop1_q   <= rx_s;
                        cnt_q     <= FULL_M1;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        state_q   <= S_STOP2;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_STOP2: begin
                    if (tick_s) begin
                        stop2_q   <= rx_s;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    rx_data_q      <= shift_q;
                    check_parity_q <= (par_bit_q == calc_parity(shift_q));
                    frame_err_q    <= ~(stop1_q & stop2_q);
                    rx_valid_q     <= 1'b1;
                    // A start edge landing here begins the next frame without losing it
                    if (fall_s) begin
                        cnt_q     <= HALF_M1;
                        bit_cnt_q <= 4'd0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench: directed and random frames against a frame-level
// reference model; even- and odd-parity receivers share the same line.
module tb_uart_frame_receiver;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       key0;
    logic       rx;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       cp_a, cp_b, fe_a, fe_b, busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] d;
        logic       ok_even;
        logic       ok_odd;
        logic       ferr;
    } exp_t;

    exp_t expq[$];
    int   vcyc[$];
    logic prev_valid = 1'b0;

    uart_frame_receiver #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut_a (
        .CLOCK_125_p(clk), .KEY0(key0), .Rx(rx),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .check_parity(cp_a),
        .frame_err(fe_a), .busy(busy_a)
    );

    uart_frame_receiver #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_b (
        .CLOCK_125_p(clk), .KEY0(key0), .Rx(rx),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .check_parity(cp_b),
        .frame_err(fe_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame-level reference: parity judged from the count of ones, framing from both stops
    function automatic exp_t model(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        exp_t e;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        e.d       = d;
        e.ok_even = (p == logic'(ones % 2));
        e.ok_odd  = (p == logic'((ones + 1) % 2));
        e.ferr    = !(s1 && s2);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rx_valid_a || rx_valid_b) begin
            exp_t e;
            vcyc.push_back(cyc);
            chk("valid_pair", 32'(rx_valid_b), 32'(rx_valid_a));
            chk("valid_pulse_width", 32'(prev_valid), 32'(0));
            chk("valid_expected", 32'(expq.size() > 0), 32'(1));
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rx_data", 32'(rx_data_a), 32'(e.d));
                chk("rx_data_odd", 32'(rx_data_b), 32'(e.d));
                chk("parity_even", 32'(cp_a), 32'(e.ok_even));
                chk("parity_odd", 32'(cp_b), 32'(e.ok_odd));
                chk("frame_err", 32'(fe_a), 32'(e.ferr));
                chk("busy_at_valid", 32'(busy_a), 32'(0));
            end
        end
        prev_valid = rx_valid_a;
    end

    int fall_cyc;

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        logic [11:0] bits;
        bits = {s2, s1, p, d, 1'b0};
        expq.push_back(model(d, p, s1, s2));
        fall_cyc = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            rx = bits[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * C) @(negedge clk);
    endtask

    initial begin
        int   vbase;
        logic [7:0] d;
        logic p, s1, s2;
        logic [7:0] v55;

        rx   = 1'b1;
        key0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data_a), 32'(0));
        chk("reset_rx_valid", 32'(rx_valid_a), 32'(0));
        chk("reset_check_parity", 32'(cp_a), 32'(0));
        chk("reset_frame_err", 32'(fe_a), 32'(0));
        chk("reset_busy", 32'(busy_a), 32'(0));
        key0 = 1'b1;
        idle_bits(1);

        // Single good frame and its latency from the Rx fall
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        chk("t1_consumed", 32'(expq.size()), 32'(0));
        chk("t1_count", 32'(vcyc.size()), 32'(1));
        if (vcyc.size() == 1) chk("t1_latency", 32'(vcyc[0] - fall_cyc), 32'(95));

        send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
        idle_bits(2);
        chk("t2_parity_even", 32'(cp_a), 32'(0));
        chk("t2_parity_odd", 32'(cp_b), 32'(1));

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        chk("t3_ferr_set", 32'(fe_a), 32'(1));
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        chk("t3_ferr_clear", 32'(fe_a), 32'(0));
        chk("t3_consumed", 32'(expq.size()), 32'(0));

        // False start: two-cycle low glitch
        vbase = vcyc.size();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_busy_rise", 32'(busy_a), 32'(1));
        repeat (4) @(negedge clk);
        chk("t4_busy_fall", 32'(busy_a), 32'(0));
        idle_bits(2);
        chk("t4_no_valid", 32'(vcyc.size()), 32'(vbase));
        chk("t4_data_kept", 32'(rx_data_a), 32'(8'h3C));
        chk("t4_parity_kept", 32'(cp_a), 32'(1));

        // Reset pulse during data bit 4 of 0x55
        v55 = 8'h55;
        rx  = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = v55[i];
            repeat (C) @(negedge clk);
        end
        rx = v55[4];
        repeat (C / 2) @(negedge clk);
        key0 = 1'b0;
        #1;
        chk("t5_rst_data", 32'(rx_data_a), 32'(0));
        chk("t5_rst_valid", 32'(rx_valid_a), 32'(0));
        chk("t5_rst_parity", 32'(cp_a), 32'(0));
        chk("t5_rst_ferr", 32'(fe_a), 32'(0));
        chk("t5_rst_busy", 32'(busy_a), 32'(0));
        @(negedge clk);
        key0 = 1'b1;
        idle_bits(2);
        chk("t5_no_valid", 32'(vcyc.size()), 32'(vbase));
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        chk("t5_next_data", 32'(rx_data_a), 32'(8'h81));

        // Back-to-back frames with no idle gap
        vbase = vcyc.size();
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        chk("t6_count", 32'(vcyc.size()), 32'(vbase + 3));
        if (vcyc.size() == vbase + 3) begin
            chk("t6_gap1", 32'(vcyc[vbase + 1] - vcyc[vbase]), 32'(12 * C));
            chk("t6_gap2", 32'(vcyc[vbase + 2] - vcyc[vbase + 1]), 32'(12 * C));
        end

        // Break: line held low for many frame times yields one errored frame
        vbase = vcyc.size();
        expq.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
        rx = 1'b0;
        repeat (30 * C) @(negedge clk);
        idle_bits(2);
        chk("brk_count", 32'(vcyc.size()), 32'(vbase + 1));
        chk("brk_ferr", 32'(fe_a), 32'(1));

        // Random frames: random data, parity and stop bits, short random gaps
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom_range(255, 0));
            p  = 1'($urandom_range(1, 0));
            s1 = ($urandom_range(3, 0) != 0);
            s2 = ($urandom_range(3, 0) != 0);
            send_frame(d, p, s1, s2);
            if (!s2) begin
                idle_bits($urandom_range(2, 1));
            end else begin
                idle_bits($urandom_range(2, 0));
            end
        end
        idle_bits(2);
        chk("final_consumed", 32'(expq.size()), 32'(0));
        chk("final_busy", 32'(busy_a), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
